pipe_hazard_unit: RTL and testbench
===================================

# pipe_hazard_unit

Parametrised hazard-detection and forwarding controller for the pipelined MIPS core; it replaces the fixed-depth hazard detector and forwarding unit with a single block. It sits beside the ID stage, tracks the destination tag of every in-flight instruction in a shift-register scoreboard of configurable depth, and produces stall/bubble control. It also produces registered forwarding selects that are valid when the ID-stage instruction reaches EX.

## Interface
Parameters:
- REG_AW, 5, register-address width.
- DEPTH, 3, post-ID stages tracked (EX, MEM, WB); legal range 2..7.
- LOAD_LAT, 2, first distance at which load data may be forwarded; legal range 1..DEPTH.
- FW_W, $clog2(DEPTH+1), forward-select width (derived, not overridden).

Ports:
- clk_i  in  1  core clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- issue_valid_i  in  1  ID stage holds a valid instruction.
- rs_i, rt_i  in  REG_AW  source register addresses of the ID instruction.
- rs_use_i, rt_use_i  in  1  the respective source is actually read.
- rd_i  in  REG_AW  destination register of the ID instruction.
- reg_write_i  in  1  ID instruction writes rd_i.
- mem_read_i  in  1  ID instruction is a load.
- flush_i  in  1  taken branch/jump; kills the ID instruction.
- stall_o  out  1  hold PC and IF/ID this cycle.
- bubble_o  out  1  insert NOP into ID/EX this cycle; equals stall_o.
- fwd_rs_o, fwd_rt_o  out  FW_W  EX-stage operand source: 0 = ID/EX register value, d = result of producer d stages ahead (1 = EX/MEM, 2 = MEM/WB, 3 = WB write data, ...).
- pending_o  out  DEPTH  valid bit per scoreboard entry (debug).

## Operation
- Scoreboard entry e[d], d = 1..DEPTH, holds {valid, rd, wr, ld}. e[1] is the instruction currently in EX, and e[DEPTH] is the one in WB.
- Match for source s at distance d: s_use & e[d].valid & e[d].wr & e[d].rd == s & s != 0. Register 0 never matches.
- For each source, select the smallest matching d (youngest producer). If there is no match, the source is 0.
- Load-use hazard: the selected entry has ld = 1 and d < LOAD_LAT.
- stall_o = issue_valid_i & hazard(rs | rt) & ~flush_i.
- Shift every cycle: e[d+1] <= e[d]; e[DEPTH] is discarded.
- e[1] <= {issue_valid_i & ~stall_o & ~flush_i, rd_i, reg_write_i, mem_read_i}. A stalled or flushed slot enters as invalid.
- fwd_*_o register the selected distance when issue is accepted; otherwise they register 0.
- After a stall, the load has advanced one stage, so re-evaluation yields distance LOAD_LAT and no further stall (1 stall cycle for default LOAD_LAT = 2).

## Timing
- stall_o and bubble_o are combinational from inputs and scoreboard state, in the same cycle as the ID instruction.
- fwd_*_o have 1-cycle latency: they are valid during the cycle the instruction occupies EX.
- Reset (asynchronous, any time including mid-stall): all entries invalid, fwd_*_o = 0, pending_o = 0, stall_o = 0 while the scoreboard is empty.
- flush_i together with a hazard: flush wins, so stall_o = 0 and e[1] becomes invalid.
- issue_valid_i = 0: stall_o = 0 and the scoreboard drains normally.

## Configuration
- HAZARD_STATS_EN defined:
  - Adds output stall_cnt_o (32-bit), which counts cycles with stall_o = 1 and saturates at 0xFFFFFFFF.
  - The counter is cleared by rst_i.
- HAZARD_STATS_EN undefined: the port and the counter are absent.

## Test plan
- ALU back-to-back dependency: add r1 then add r2,r1,r3 → stall_o = 0; next cycle fwd_rs_o = 1, fwd_rt_o = 0.
- Load-use: lw r1 then add r2,r1,r1 → stall_o = 1 for exactly 1 cycle and pending_o shows a bubble; then fwd_rs_o = fwd_rt_o = 2.
- r0 destination: add r0 then add r2,r0,r0 → no stall, fwd = 0.
- Youngest producer wins: writers of r3 at d = 2 and d = 1, consumer reads r3 → fwd_rs_o = 1.
- Flush priority: load-use hazard with flush_i = 1 → stall_o = 0; e[1] invalid next cycle (pending_o[0] = 0).
- Reset mid-stall: assert rst_i during a load-use stall → stall_o = 0, pending_o = 0, fwd = 0 immediately. With HAZARD_STATS_EN, stall_cnt_o = 0.

Source files
------------

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit
//   Hazard-detection and forwarding controller for the pipelined MIPS core.
//   It tracks the destination tag of every in-flight instruction in a
//   shift-register scoreboard (e[1] = EX ... e[DEPTH] = WB). It also raises a
//   load-use stall combinationally, and registers the forwarding selects that
//   apply once the ID instruction reaches EX.
//
// Parameters
//   REG_AW   register-address width
//   DEPTH    post-ID stages tracked (2..7)
//   LOAD_LAT first distance at which load data may be forwarded (1..DEPTH)
//   FW_W     forward-select width, derived from DEPTH
//
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   issue_valid_i                ID stage holds a valid instruction
//   rs_i/rt_i, rs_use_i/rt_use_i source registers and their read enables
//   rd_i, reg_write_i            destination register and its write enable
//   mem_read_i                   ID instruction is a load
//   flush_i                      kills the ID instruction (wins over stall)
//   stall_o, bubble_o            hold PC/IF-ID, insert NOP into ID/EX
//   fwd_rs_o, fwd_rt_o           EX operand source: 0 = ID/EX, d = producer d ahead
//   pending_o                    valid bit per scoreboard entry (bit 0 = EX)
//   stall_cnt_o                  saturating stall-cycle counter (HAZARD_STATS_EN only)
//
// Optional feature macro: HAZARD_STATS_EN

module pipe_hazard_unit #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned LOAD_LAT = 2,
  localparam int unsigned FW_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_valid_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic [REG_AW-1:0] rt_i,
  input  logic              rs_use_i,
  input  logic              rt_use_i,
  input  logic [REG_AW-1:0] rd_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [FW_W-1:0]   fwd_rs_o,
  output logic [FW_W-1:0]   fwd_rt_o,
  output logic [DEPTH-1:0]  pending_o
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam logic [FW_W-1:0] LOAD_LAT_W = FW_W'(LOAD_LAT);

  logic [DEPTH:1]    sb_valid;
  logic [DEPTH:1]    sb_wr;
  logic [DEPTH:1]    sb_ld;
  logic [REG_AW-1:0] sb_rd [DEPTH:1];

  logic [FW_W-1:0] dist_rs;
  logic [FW_W-1:0] dist_rt;
  logic            ld_rs;
  logic            ld_rt;
  logic            haz_rs;
  logic            haz_rt;
  logic            stall;
  logic            accept;

  // Walk from the oldest entry toward EX so that the nearest (youngest)
  // matching producer is the last one assigned and therefore wins.
  always_comb begin
    dist_rs = '0;
    dist_rt = '0;
    ld_rs   = 1'b0;
    ld_rt   = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (rs_use_i && (rs_i != '0) && sb_valid[DEPTH-k] && sb_wr[DEPTH-k] &&
          (sb_rd[DEPTH-k] == rs_i)) begin
        dist_rs = FW_W'(DEPTH - k);
        ld_rs   = sb_ld[DEPTH-k];
      end
      if (rt_use_i && (rt_i != '0) && sb_valid[DEPTH-k] && sb_wr[DEPTH-k] &&
          (sb_rd[DEPTH-k] == rt_i)) begin
        dist_rt = FW_W'(DEPTH - k);
        ld_rt   = sb_ld[DEPTH-k];
      end
    end
  end

  // A matching distance is never 0, so ld_* alone qualifies the compare.
  assign haz_rs = ld_rs && (dist_rs < LOAD_LAT_W);
  assign haz_rt = ld_rt && (dist_rt < LOAD_LAT_W);

  assign stall    = issue_valid_i && (haz_rs || haz_rt) && !flush_i;
  assign accept   = issue_valid_i && !stall && !flush_i;
  assign stall_o  = stall;
  assign bubble_o = stall;
  assign pending_o = sb_valid;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sb_valid <= '0;
      sb_wr    <= '0;
      sb_ld    <= '0;
      for (int unsigned d = 1; d <= DEPTH; d++) begin
        sb_rd[d] <= '0;
      end
      fwd_rs_o <= '0;
      fwd_rt_o <= '0;
    end else begin
      sb_valid <= {sb_valid[DEPTH-1:1], accept};
      sb_wr    <= {sb_wr[DEPTH-1:1], reg_write_i};
      sb_ld    <= {sb_ld[DEPTH-1:1], mem_read_i};
      for (int unsigned d = DEPTH; d >= 2; d--) begin
        sb_rd[d] <= sb_rd[d-1];
      end
      sb_rd[1] <= rd_i;
      fwd_rs_o <= accept ? dist_rs : '0;
      fwd_rt_o <= accept ? dist_rt : '0;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall && (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
`timescale 1ns/1ps
module tb_pipe_hazard_unit;

  localparam int DEPTH    = 3;
  localparam int LOAD_LAT = 2;
  localparam int FW_W     = $clog2(DEPTH + 1);

  logic            clk = 1'b0;
  logic            rst;
  logic            issue_valid;
  logic [4:0]      rs, rt, rd;
  logic            rs_use, rt_use, reg_write, mem_read, flush;
  logic            stall, bubble;
  logic [FW_W-1:0] fwd_rs, fwd_rt;
  logic [DEPTH-1:0] pending;
`ifdef HAZARD_STATS_EN
  logic [31:0]     stall_cnt;
`endif

  pipe_hazard_unit #(.REG_AW(5), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .issue_valid_i(issue_valid),
    .rs_i(rs), .rt_i(rt), .rs_use_i(rs_use), .rt_use_i(rt_use),
    .rd_i(rd), .reg_write_i(reg_write), .mem_read_i(mem_read), .flush_i(flush),
    .stall_o(stall), .bubble_o(bubble), .fwd_rs_o(fwd_rs), .fwd_rt_o(fwd_rt),
    .pending_o(pending)
`ifdef HAZARD_STATS_EN
    , .stall_cnt_o(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string name, longint act, longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight instructions, index 0 = EX (distance 1).
  typedef struct { bit v; int rd; bit wr; bit ld; } ent_t;
  ent_t   q[$];
  int     exp_fwd_rs, exp_fwd_rt;
  longint exp_cnt;

  function automatic int nearest(bit use_s, int s);
    if (!use_s || s == 0) return 0;
    for (int d = 1; d <= DEPTH; d++)
      if (q[d-1].v && q[d-1].wr && q[d-1].rd == s) return d;
    return 0;
  endfunction

  function automatic bit is_haz(int d);
    return (d != 0) && q[d-1].ld && (d < LOAD_LAT);
  endfunction

  always @(negedge clk) begin
    int  drs, drt, pend;
    bit  exp_stall, acc;
    ent_t e;
    if (rst) begin
      q.delete();
      for (int i = 0; i < DEPTH; i++) q.push_back('{v:0, rd:0, wr:0, ld:0});
      exp_fwd_rs = 0;
      exp_fwd_rt = 0;
      exp_cnt    = 0;
      chk("rst_stall", stall, 0);
      chk("rst_pending", pending, 0);
      chk("rst_fwd_rs", fwd_rs, 0);
      chk("rst_fwd_rt", fwd_rt, 0);
`ifdef HAZARD_STATS_EN
      chk("rst_cnt", stall_cnt, 0);
`endif
    end else begin
      drs = nearest(rs_use, rs);
      drt = nearest(rt_use, rt);
      exp_stall = issue_valid && (is_haz(drs) || is_haz(drt)) && !flush;
      pend = 0;
      for (int d = 1; d <= DEPTH; d++) if (q[d-1].v) pend += (1 << (d-1));
      chk("stall", stall, exp_stall);
      chk("bubble", bubble, exp_stall);
      chk("pending", pending, pend);
      chk("fwd_rs", fwd_rs, exp_fwd_rs);
      chk("fwd_rt", fwd_rt, exp_fwd_rt);
`ifdef HAZARD_STATS_EN
      chk("stall_cnt", stall_cnt, exp_cnt);
      if (exp_stall && exp_cnt != 64'hFFFF_FFFF) exp_cnt++;
`endif
      // advance to the state after the coming rising edge
      acc = issue_valid && !exp_stall && !flush;
      e.v = acc; e.rd = rd; e.wr = reg_write; e.ld = mem_read;
      q.push_front(e);
      void'(q.pop_back());
      exp_fwd_rs = acc ? drs : 0;
      exp_fwd_rt = acc ? drt : 0;
    end
  end

  task automatic drive(bit v, int s, int t, bit su, bit tu, int d, bit w, bit l, bit f);
    @(posedge clk);
    #1;
    issue_valid = v; rs = 5'(s); rt = 5'(t); rs_use = su; rt_use = tu;
    rd = 5'(d); reg_write = w; mem_read = l; flush = f;
  endtask

  task automatic idle(int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    issue_valid = 0; rs = 0; rt = 0; rs_use = 0; rt_use = 0;
    rd = 0; reg_write = 0; mem_read = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // ALU back-to-back: add r1 ; add r2,r1,r3
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 1, 3, 1, 1, 2, 1, 0, 0);
    #2 chk("alu_stall", stall, 0);
    idle(1);
    #2 chk("alu_fwd_rs", fwd_rs, 1);
    chk("alu_fwd_rt", fwd_rt, 0);

    // Load-use: lw r1 ; add r2,r1,r1 (held one cycle)
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    #2 chk("lu_stall", stall, 1);
    chk("lu_bubble", bubble, 1);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    #2 chk("lu_stall_released", stall, 0);
    chk("lu_pending", pending, 3'b010);
    idle(1);
    #2 chk("lu_fwd_rs", fwd_rs, 2);
    chk("lu_fwd_rt", fwd_rt, 2);

    // r0 destination never forwards
    idle(3);
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1, 0, 0, 1, 1, 2, 1, 0, 0);
    #2 chk("r0_stall", stall, 0);
    idle(1);
    #2 chk("r0_fwd_rs", fwd_rs, 0);
    chk("r0_fwd_rt", fwd_rt, 0);

    // Youngest producer wins
    idle(3);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    drive(1, 3, 0, 1, 0, 4, 1, 0, 0);
    idle(1);
    #2 chk("young_fwd_rs", fwd_rs, 1);

    // Flush beats load-use hazard
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
    drive(1, 1, 0, 1, 0, 2, 1, 0, 1);
    #2 chk("flush_stall", stall, 0);
    idle(1);
    #2 chk("flush_pending0", pending[0], 0);
    chk("flush_fwd_rs", fwd_rs, 0);

    // Reset in the middle of a load-use stall
    idle(3);
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 1, 2, 1, 0, 0);
    #2 chk("mid_stall", stall, 1);
    rst = 1'b1;
    #0.5;
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_pending", pending, 0);
    chk("mid_rst_fwd_rs", fwd_rs, 0);
    chk("mid_rst_fwd_rt", fwd_rt, 0);
`ifdef HAZARD_STATS_EN
    chk("mid_rst_cnt", stall_cnt, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;

    // Randomized traffic over a small register set to provoke hazards
    repeat (800) begin
      drive(($urandom_range(0, 9) < 8), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
            ($urandom_range(0, 9) == 0));
    end
    idle(2);
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
